// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: buffers an Avalon-ST pixel stream (st_*) in a FIFO and writes one frame of frame_words_i words at frame_base_i as Avalon-MM bursts (sdram_*), with start_i/busy_o/done_o control
module sdram_frame_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 29,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   frame_base_i,
  input  logic [23:0]             frame_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  output logic [ADDR_WIDTH-1:0]   sdram_address_o,
  output logic [7:0]              sdram_burstcount_o,
  output logic                    sdram_write_o,
  output logic [DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [DATA_WIDTH/8-1:0] sdram_byteenable_o,
  input  logic                    sdram_waitrequest_i
);
  localparam int AW_F = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, address_n;
  logic [23:0] frame_words, frame_words_n, remaining, remaining_n, accepted;
  logic [7:0] beat_cnt, beat_cnt_n, burstcount_n, blen;
  logic write_n, push, pop;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW_F-1:0] wr_ptr, rd_ptr;
  logic [AW_F:0] fifo_count;
  assign busy_o = state == WAIT || state == BURST;
  assign done_o = state == DONE;
  assign st_ready_o = busy_o && !fifo_count[AW_F] && accepted < frame_words;
  assign push = st_valid_i && st_ready_o;
  assign pop = sdram_write_o && !sdram_waitrequest_i;
  assign blen = remaining > 24'(BURST_LEN) ? 8'(BURST_LEN) : remaining[7:0];
  assign sdram_writedata_o = mem[rd_ptr];
  assign sdram_byteenable_o = '1;
  always_comb begin
    state_n = state;
    addr_n = addr;
    frame_words_n = frame_words;
    remaining_n = remaining;
    beat_cnt_n = beat_cnt;
    address_n = sdram_address_o;
    burstcount_n = sdram_burstcount_o;
    write_n = sdram_write_o;
    case (state)
      IDLE: if (start_i) begin
        frame_words_n = frame_words_i;
        remaining_n = frame_words_i;
        addr_n = frame_base_i;
        state_n = frame_words_i == 24'd0 ? DONE : WAIT;
      end
      WAIT: if (24'(fifo_count) >= 24'(blen)) begin
        address_n = addr;
        burstcount_n = blen;
        write_n = 1'b1;
        beat_cnt_n = 8'd0;
        state_n = BURST;
      end
      BURST: if (pop) begin
        beat_cnt_n = beat_cnt + 8'd1;
        if (beat_cnt == sdram_burstcount_o - 8'd1) begin
          write_n = 1'b0;
          remaining_n = remaining - 24'(sdram_burstcount_o);
          addr_n = addr + ADDR_WIDTH'(sdram_burstcount_o);
          state_n = remaining == 24'(sdram_burstcount_o) ? DONE : WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      frame_words <= '0;
      remaining <= '0;
      beat_cnt <= '0;
      sdram_address_o <= '0;
      sdram_burstcount_o <= '0;
      sdram_write_o <= 1'b0;
      accepted <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      frame_words <= frame_words_n;
      remaining <= remaining_n;
      beat_cnt <= beat_cnt_n;
      sdram_address_o <= address_n;
      sdram_burstcount_o <= burstcount_n;
      sdram_write_o <= write_n;
      accepted <= state == IDLE && start_i ? 24'd0 : accepted + 24'(push);
      wr_ptr <= wr_ptr + AW_F'(push);
      rd_ptr <= rd_ptr + AW_F'(pop);
      fifo_count <= fifo_count + (AW_F+1)'(push) - (AW_F+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= st_data_i;
  end
endmodule

// File: tb/tb_sdram_frame_writer.sv
// tb_sdram_frame_writer: randomized frames checked against a per-beat model of burst layout, data order and handshakes
module tb_sdram_frame_writer;
  localparam int BL = 16;
  logic clk = 0, rst = 1, start_i = 0, busy_o, done_o, st_valid_i = 0, st_ready_o;
  logic sdram_write_o, sdram_waitrequest_i = 0;
  logic [28:0] frame_base_i = '0, sdram_address_o;
  logic [23:0] frame_words_i = '0;
  logic [63:0] st_data_i = '0, sdram_writedata_o;
  logic [7:0] sdram_burstcount_o, sdram_byteenable_o;
  logic [63:0] exp_w [0:255];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  sdram_frame_writer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .frame_base_i(frame_base_i),
    .frame_words_i(frame_words_i), .busy_o(busy_o), .done_o(done_o),
    .st_data_i(st_data_i), .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .sdram_address_o(sdram_address_o), .sdram_burstcount_o(sdram_burstcount_o),
    .sdram_write_o(sdram_write_o), .sdram_writedata_o(sdram_writedata_o),
    .sdram_byteenable_o(sdram_byteenable_o), .sdram_waitrequest_i(sdram_waitrequest_i)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_ready"}, st_ready_o, 0);
    chk({tag, "_write"}, sdram_write_o, 0);
    chk({tag, "_address"}, sdram_address_o, 0);
    chk({tag, "_burstcount"}, sdram_burstcount_o, 0);
  endtask
  task automatic run_frame(input logic [28:0] base, input int n, input int vpct, input int wpct,
                           input int dup_at, input int abort_at);
    int sent = 0, beat = 0, last_cyc = 0, blk, ebc;
    bit done = 0;
    logic [28:0] ea;
    for (int i = 0; i < n; i++) exp_w[i] = {$urandom, $urandom};
    @(negedge clk);
    start_i = 1;
    frame_base_i = base;
    frame_words_i = 24'(n);
    st_valid_i = 0;
    sdram_waitrequest_i = 0;
    for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
      @(negedge clk);
      start_i = cyc == dup_at;
      if (start_i) begin
        frame_base_i = 29'($urandom);
        frame_words_i = 24'd7;
      end
      if (beat % BL != 0 && beat < n) chk("no_gap", sdram_write_o, 1);
      if (sdram_write_o) begin
        blk = beat / BL;
        ea = base + 29'(blk * BL);
        ebc = n - blk * BL > BL ? BL : n - blk * BL;
        chk("in_frame", beat < n, 1);
        chk("address", sdram_address_o, ea);
        chk("burstcount", sdram_burstcount_o, 8'(ebc));
        chk("writedata", sdram_writedata_o, exp_w[beat & 255]);
        chk("byteenable", sdram_byteenable_o, 8'hff);
        if (beat % BL == 0) chk("buffered", sent - beat >= ebc, 1);
      end
      if (done_o) begin
        chk("done_beats", beat, n);
        chk("done_latency", cyc, last_cyc + 1);
        done = 1;
      end else chk("busy", busy_o, 1);
      if (beat == abort_at) begin
        rst = 1;
        st_valid_i = 0;
        start_i = 0;
        @(negedge clk);
        chk_reset_outputs("abort");
        rst = 0;
        return;
      end
      st_valid_i = $urandom_range(99) < vpct;
      st_data_i = sent < n ? exp_w[sent] : {$urandom, $urandom};
      sdram_waitrequest_i = $urandom_range(99) < wpct;
      if (st_valid_i && st_ready_o) begin
        chk("no_overrun", sent < n, 1);
        sent++;
      end
      if (sdram_write_o && !sdram_waitrequest_i) begin
        beat++;
        last_cyc = cyc;
      end
    end
    chk("timeout", done, 1);
    @(negedge clk);
    start_i = 0;
    st_valid_i = 0;
    sdram_waitrequest_i = 0;
    chk("done_pulse", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_write", sdram_write_o, 0);
    chk("idle_ready", st_ready_o, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    run_frame(29'h100, 32, 100, 0, -1, -1);
    run_frame(29'h200, 20, 100, 0, -1, -1);
    run_frame(29'($urandom), 37, 100, 50, -1, -1);
    run_frame(29'h300, 48, 25, 0, -1, -1);
    run_frame(29'h400, 24, 100, 30, 3, -1);
    run_frame(29'h480, 0, 100, 0, -1, -1);
    run_frame(29'h500, 32, 100, 0, -1, 5);
    run_frame(29'h600, 40, 80, 30, -1, -1);
    run_frame(29'h1ffffff8, 40, 100, 20, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
